// File: rtl/gpi_debounce_if.sv
// Bus between the raw-input conditioner and its user: raw levels and flag
// clears in, debounced levels and sticky rising-edge flags out.
interface gpi_debounce_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] raw_in;
    logic             clr_en;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] edge_out;

    modport master (
        output raw_in,
        output clr_en,
        output clr_mask,
        input  clean_out,
        input  edge_out
    );

    modport slave (
        input  raw_in,
        input  clr_en,
        input  clr_mask,
        output clean_out,
        output edge_out
    );
endinterface

// File: rtl/gpi_debounce.sv
// Two-flop synchroniser, shared sample tick and per-bit stability counters per input;
// sticky rising-edge flags are built only when GPI_DEBOUNCE_EDGE_EN is defined.
module gpi_debounce #(
    parameter int WIDTH    = 32,
    parameter int TICK_DIV = 50000,
    parameter int STABLE   = 4
) (
    input  logic           clk,
    input  logic           rst,
    gpi_debounce_if.slave  bus_io
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             tick;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus_io.raw_in;
            sync2_q <= sync1_q;
        end
    end

    // With TICK_DIV=1 the count is pinned at 0 and tick is high every cycle.
    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          bit_d;

        // The counter tracks consecutive ticks disagreeing with the clean level;
        // any agreeing tick restarts it, so it never passes STABLE-1.
        always_comb begin
            cnt_d = cnt_q;
            bit_d = clean_q[gi];
            if (tick) begin
                if (sync2_q[gi] == clean_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    bit_d = ~clean_q[gi];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign clean_d[gi] = bit_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clean_q <= '0;
        end else begin
            clean_q <= clean_d;
        end
    end

    assign bus_io.clean_out = clean_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;

    assign rise = clean_d & ~clean_q;

    // A rise in the same cycle as a clear of that bit keeps the flag set.
    always_comb begin
        edge_d = (edge_q & ~(bus_io.clr_en ? bus_io.clr_mask : '0)) | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign bus_io.edge_out = edge_q;
`else
    logic unused_clr;
    assign unused_clr      = &{1'b0, bus_io.clr_en, bus_io.clr_mask};
    assign bus_io.edge_out = '0;
`endif
endmodule

// File: tb/tb_gpi_debounce.sv
// Checks two debouncer instances (4/3 and 1/1 tick/stable settings) against a
// tick-and-run-length model, plus directed literal scenarios and random bouncing.
module tb_gpi_debounce;
    localparam int W = 32;
`ifdef GPI_DEBOUNCE_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gpi_debounce_if #(.WIDTH(W)) a_if ();
    gpi_debounce_if #(.WIDTH(W)) b_if ();

    gpi_debounce #(.WIDTH(W), .TICK_DIV(4), .STABLE(3)) dut_a (
        .clk(clk), .rst(rst), .bus_io(a_if.slave));
    gpi_debounce #(.WIDTH(W), .TICK_DIV(1), .STABLE(1)) dut_b (
        .clk(clk), .rst(rst), .bus_io(b_if.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ex(input logic [31:0] v);
        return EDGE_ON ? v : 32'h0;
    endfunction

    // Behavioural model: index 0 is instance A, index 1 is instance B.
    int          tdiv [2] = '{4, 1};
    int          stab [2] = '{3, 1};
    logic [31:0] m_s1 [2];
    logic [31:0] m_s2 [2];
    logic [31:0] m_clean [2];
    logic [31:0] m_edge [2];
    int          m_run [2][32];
    int          m_cyc [2];

    task automatic model_step(input int k, input logic [31:0] raw, input logic ce,
                              input logic [31:0] cm);
        logic [31:0] rise;
        bit          tick;
        if (!rst) begin
            m_s1[k] = '0; m_s2[k] = '0; m_clean[k] = '0; m_edge[k] = '0;
            for (int b = 0; b < 32; b++) m_run[k][b] = 0;
            m_cyc[k] = 0;
            return;
        end
        tick = ((m_cyc[k] % tdiv[k]) == tdiv[k] - 1);
        m_cyc[k]++;
        rise = '0;
        if (tick) begin
            for (int b = 0; b < 32; b++) begin
                if (m_s2[k][b] != m_clean[k][b]) begin
                    m_run[k][b]++;
                    if (m_run[k][b] == stab[k]) begin
                        m_clean[k][b] = ~m_clean[k][b];
                        m_run[k][b] = 0;
                        if (m_clean[k][b]) rise[b] = 1'b1;
                    end
                end else begin
                    m_run[k][b] = 0;
                end
            end
        end
        m_edge[k] = ex((m_edge[k] & ~(ce ? cm : 32'h0)) | rise);
        m_s2[k] = m_s1[k];
        m_s1[k] = raw;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, a_if.raw_in, a_if.clr_en, a_if.clr_mask);
            model_step(1, b_if.raw_in, b_if.clr_en, b_if.clr_mask);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("a_clean", a_if.clean_out, rst ? m_clean[0] : 32'h0);
            check("a_edge",  a_if.edge_out,  rst ? m_edge[0]  : 32'h0);
            check("b_clean", b_if.clean_out, rst ? m_clean[1] : 32'h0);
            check("b_edge",  b_if.edge_out,  rst ? m_edge[1]  : 32'h0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        a_if.raw_in = 32'hFFFF_FFFF; a_if.clr_en = 1'b0; a_if.clr_mask = '0;
        b_if.raw_in = '0;            b_if.clr_en = 1'b0; b_if.clr_mask = '0;
        rst = 1'b0;

        cycles(10);
        check("rst_clean", a_if.clean_out, 32'h0);
        check("rst_edge",  a_if.edge_out,  32'h0);
        rst = 1'b1;
        cycles(11);
        check("rel_clean_early", a_if.clean_out, 32'h0);
        cycles(3);
        check("rel_clean", a_if.clean_out, 32'hFFFF_FFFF);
        check("rel_edge",  a_if.edge_out,  ex(32'hFFFF_FFFF));

        a_if.clr_en = 1'b1; a_if.clr_mask = 32'hFFFF_FFFF;
        cycles(1);
        a_if.clr_en = 1'b0;
        check("clr_all", a_if.edge_out, 32'h0);

        b_if.raw_in = 32'hA5;
        cycles(2);
        check("min_early", b_if.clean_out, 32'h0);
        cycles(1);
        check("min_step", b_if.clean_out, 32'hA5);
        check("min_edge", b_if.edge_out, ex(32'hA5));

        a_if.raw_in = 32'h0;
        cycles(16);
        check("fall_clean", a_if.clean_out, 32'h0);
        check("fall_no_edge", a_if.edge_out, 32'h0);

        a_if.raw_in = 32'h21;
        cycles(10);
        check("press_early", a_if.clean_out, 32'h0);
        cycles(4);
        check("press_clean", a_if.clean_out, 32'h21);
        check("press_edge", a_if.edge_out, ex(32'h21));

        a_if.raw_in = 32'h29;
        cycles(5);
        a_if.raw_in = 32'h21;
        cycles(20);
        check("glitch_clean", a_if.clean_out, 32'h21);
        check("glitch_edge", a_if.edge_out, ex(32'h21));

        a_if.clr_en = 1'b1; a_if.clr_mask = 32'h1;
        cycles(1);
        a_if.clr_en = 1'b0;
        check("clr_bit0", a_if.edge_out, ex(32'h20));

        a_if.raw_in = 32'h20;
        cycles(16);
        check("release_clean", a_if.clean_out, 32'h20);
        check("release_edge", a_if.edge_out, ex(32'h20));

        // Hold the clear on bit 0 across its next rise: the set must win.
        a_if.raw_in = 32'h21; a_if.clr_en = 1'b1; a_if.clr_mask = 32'h1;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (a_if.clean_out[0]) break;
        end
        check("clr_set_rise", {31'h0, a_if.clean_out[0]}, 32'h1);
        check("clr_set_edge", a_if.edge_out, ex(32'h21));
        a_if.clr_en = 1'b0;
        cycles(1);
        check("clr_set_hold", a_if.edge_out, ex(32'h21));

        a_if.raw_in = 32'h1A1;
        cycles(6);
        #2 rst = 1'b0;
        #1;
        check("async_a_clean", a_if.clean_out, 32'h0);
        check("async_a_edge",  a_if.edge_out,  32'h0);
        check("async_b_clean", b_if.clean_out, 32'h0);
        check("async_b_edge",  b_if.edge_out,  32'h0);
        cycles(3);
        rst = 1'b1;
        cycles(11);
        check("restart_early", a_if.clean_out, 32'h0);
        cycles(3);
        check("restart_clean", a_if.clean_out, 32'h1A1);
        check("restart_edge", a_if.edge_out, ex(32'h1A1));

        for (int seg = 0; seg < 30; seg++) begin
            int mode;
            mode = $urandom_range(0, 2);
            if (seg == 15) begin
                rst = 1'b0;
                cycles(2);
                rst = 1'b1;
            end
            for (int c = 0; c < 100; c++) begin
                if (mode == 1) begin
                    a_if.raw_in ^= $urandom & $urandom & $urandom & $urandom;
                    b_if.raw_in ^= $urandom & $urandom & $urandom & $urandom;
                end else if (mode == 2) begin
                    a_if.raw_in ^= $urandom & $urandom & 32'h0000_FFFF;
                    b_if.raw_in ^= $urandom & $urandom & 32'hFFFF_0000;
                end
                a_if.clr_en = ($urandom_range(0, 7) == 0);
                a_if.clr_mask = $urandom;
                b_if.clr_en = ($urandom_range(0, 7) == 0);
                b_if.clr_mask = $urandom;
                cycles(1);
            end
        end
        a_if.clr_en = 1'b0;
        b_if.clr_en = 1'b0;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
